// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by the fetch stage and its PC register.
package mips_pkg;

  typedef logic [31:0] pc_t;

  localparam pc_t         RESET_PC = 32'h0000_3000;
  localparam pc_t         PC_SPAN  = 32'h0001_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [31:0] instr;
    pc_t         pc;
    pc_t         pc8;
    logic        valid;
  } if_id_t;

  function automatic pc_t pc_add(pc_t a, logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Architectural fetch PC register.
// Loads d_i when en_i is high, holds otherwise.
module pc_reg
  import mips_pkg::*;
#(
  parameter pc_t RESET_VAL = mips_pkg::RESET_PC
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  pc_t  d_i,
  output pc_t  q_o
);

  pc_t pc_q;
  pc_t pc_d;

  // next PC: take the new address unless frozen
  always_comb begin
    pc_d = pc_q;
    if (en_i) pc_d = d_i;
  end

  // PC state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VAL;
    else       pc_q <= pc_d;
  end

  assign q_o = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS fetch stage: PC, IF/ID register, fetch counter.
// Optional fetch address error via IF_ADDR_EXC_EN.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter pc_t RESET_PC = mips_pkg::RESET_PC,
  parameter pc_t PC_SPAN  = mips_pkg::PC_SPAN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] newPC,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] F_pc,
  output logic [31:0] PCplus4,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8,
  output logic        D_valid,
  output logic [31:0] fetch_cnt
`ifdef IF_ADDR_EXC_EN
  ,
  output logic        D_excAdEL
`endif
);

  pc_t         pc;
  if_id_t      ifid_q;
  if_id_t      ifid_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        adel;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en_i  (~stall),
    .d_i   (newPC),
    .q_o   (pc)
  );

`ifdef IF_ADDR_EXC_EN
  logic [32:0] lo;
  logic [32:0] hi;
  logic [32:0] pc_w;
  logic        exc_q;
  logic        exc_d;

  assign lo   = {1'b0, RESET_PC};
  assign hi   = lo + {1'b0, PC_SPAN} - 33'd1;
  assign pc_w = {1'b0, pc};

  // misaligned or outside the legal window
  always_comb begin
    adel = (pc[1:0] != 2'b00) ||
           (pc_w < lo) || (pc_w > hi);
  end

  // error flag follows IF/ID: hold on stall, clear on flush
  always_comb begin
    exc_d = exc_q;
    if (stall)      exc_d = exc_q;
    else if (flush) exc_d = 1'b0;
    else            exc_d = adel;
  end

  // error flag state
  always_ff @(posedge clk) begin
    if (reset) exc_q <= 1'b0;
    else       exc_q <= exc_d;
  end

  assign D_excAdEL = exc_q;
`else
  assign adel = 1'b0;
`endif

  // IF/ID next state: stall > flush > normal
  always_comb begin
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (stall) begin
      ifid_d = ifid_q;
    end else if (flush) begin
      ifid_d.instr = NOP;
      ifid_d.pc    = pc;
      ifid_d.pc8   = pc_add(pc, 32'd8);
      ifid_d.valid = 1'b0;
    end else begin
      ifid_d.instr = adel ? NOP : im_rdata;
      ifid_d.pc    = pc;
      ifid_d.pc8   = pc_add(pc, 32'd8);
      ifid_d.valid = 1'b1;
      cnt_d        = cnt_q + 32'd1;
    end
  end

  // IF/ID and counter state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q.instr <= NOP;
      ifid_q.pc    <= RESET_PC;
      ifid_q.pc8   <= pc_add(RESET_PC, 32'd8);
      ifid_q.valid <= 1'b0;
      cnt_q        <= 32'd0;
    end else begin
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign F_pc      = pc;
  assign im_addr   = pc;
  assign PCplus4   = pc_add(pc, 32'd4);
  assign D_instr   = ifid_q.instr;
  assign D_pc      = ifid_q.pc;
  assign D_pc8     = ifid_q.pc8;
  assign D_valid   = ifid_q.valid;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage.
// Define IF_ADDR_EXC_EN to also cover the address error flag.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] newPC;
  logic        stall;
  logic        flush;
  logic [31:0] im_rdata;
  logic [31:0] im_addr;
  logic [31:0] F_pc;
  logic [31:0] PCplus4;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc8;
  logic        D_valid;
  logic [31:0] fetch_cnt;
`ifdef IF_ADDR_EXC_EN
  logic        D_excAdEL;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .newPC     (newPC),
    .stall     (stall),
    .flush     (flush),
    .im_rdata  (im_rdata),
    .im_addr   (im_addr),
    .F_pc      (F_pc),
    .PCplus4   (PCplus4),
    .D_instr   (D_instr),
    .D_pc      (D_pc),
    .D_pc8     (D_pc8),
    .D_valid   (D_valid),
    .fetch_cnt (fetch_cnt)
`ifdef IF_ADDR_EXC_EN
    ,
    .D_excAdEL (D_excAdEL)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign im_rdata = mem(im_addr);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_f(logic [31:0] pc);
    chk("F_pc", F_pc, pc);
    chk("im_addr", im_addr, pc);
    chk("PCplus4", PCplus4, pc + 32'd4);
  endtask

  task automatic exp_d(logic [31:0] pc, logic [31:0] ins,
                       logic v, logic [31:0] cnt);
    chk("D_pc", D_pc, pc);
    chk("D_pc8", D_pc8, pc + 32'd8);
    chk("D_instr", D_instr, ins);
    chk("D_valid", {31'd0, D_valid}, {31'd0, v});
    chk("fetch_cnt", fetch_cnt, cnt);
  endtask

  task automatic exp_exc(logic e);
`ifdef IF_ADDR_EXC_EN
    chk("D_excAdEL", {31'd0, D_excAdEL}, {31'd0, e});
`else
    if (e) begin end
`endif
  endtask

  // expected instruction for an address the flag may reject
  function automatic logic [31:0] ins_of(logic [31:0] a, logic bad);
`ifdef IF_ADDR_EXC_EN
    return bad ? 32'h0 : mem(a);
`else
    if (bad) return mem(a);
    return mem(a);
`endif
  endfunction

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    newPC = 32'h0000_3000;
    step();
    exp_f(32'h3000);
    exp_d(32'h3000, 32'h0, 1'b0, 0);
    exp_exc(1'b0);

    reset = 1'b0;
    newPC = 32'h3004;
    step();
    exp_f(32'h3004);
    exp_d(32'h3000, mem(32'h3000), 1'b1, 1);
    newPC = 32'h3008;
    step();
    exp_f(32'h3008);
    exp_d(32'h3004, mem(32'h3004), 1'b1, 2);

    stall = 1'b1;
    newPC = 32'h3300;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_f(32'h3008);
      exp_d(32'h3004, mem(32'h3004), 1'b1, 2);
    end
    stall = 1'b0;
    newPC = 32'h300C;
    step();
    exp_f(32'h300C);
    exp_d(32'h3008, mem(32'h3008), 1'b1, 3);

    flush = 1'b1;
    newPC = 32'h3100;
    step();
    exp_f(32'h3100);
    exp_d(32'h300C, 32'h0, 1'b0, 3);
    flush = 1'b0;
    newPC = 32'h3104;
    step();
    exp_f(32'h3104);
    exp_d(32'h3100, mem(32'h3100), 1'b1, 4);

    stall = 1'b1;
    flush = 1'b1;
    newPC = 32'h3200;
    step();
    exp_f(32'h3104);
    exp_d(32'h3100, mem(32'h3100), 1'b1, 4);
    stall = 1'b0;
    flush = 1'b0;
    newPC = 32'h3040;
    step();
    exp_f(32'h3040);
    exp_d(32'h3104, mem(32'h3104), 1'b1, 5);

    stall = 1'b1;
    newPC = 32'h3500;
    step();
    exp_f(32'h3040);
    reset = 1'b1;
    step();
    exp_f(32'h3000);
    exp_d(32'h3000, 32'h0, 1'b0, 0);
    exp_exc(1'b0);
    reset = 1'b0;
    stall = 1'b0;

    newPC = 32'hFFFF_FFFC;
    step();
    exp_f(32'hFFFF_FFFC);
    chk("PCplus4 wrap", PCplus4, 32'h0);
    exp_d(32'h3000, mem(32'h3000), 1'b1, 1);
    newPC = 32'h0;
    step();
    exp_f(32'h0);
    chk("D_pc8 wrap", D_pc8, 32'h4);
    exp_d(32'hFFFF_FFFC, ins_of(32'hFFFF_FFFC, 1'b1), 1'b1, 2);
    exp_exc(1'b1);

    newPC = 32'h3000;
    step();
    exp_d(32'h0, ins_of(32'h0, 1'b1), 1'b1, 3);
    exp_exc(1'b1);
    newPC = 32'h3002;
    step();
    exp_f(32'h3002);
    exp_d(32'h3000, mem(32'h3000), 1'b1, 4);
    exp_exc(1'b0);
    newPC = 32'h2FFC;
    step();
    exp_d(32'h3002, ins_of(32'h3002, 1'b1), 1'b1, 5);
    exp_exc(1'b1);
    newPC = 32'h0001_2FFC;
    step();
    exp_d(32'h2FFC, ins_of(32'h2FFC, 1'b1), 1'b1, 6);
    exp_exc(1'b1);
    newPC = 32'h0001_3000;
    step();
    exp_d(32'h12FFC, mem(32'h12FFC), 1'b1, 7);
    exp_exc(1'b0);

    stall = 1'b1;
    step();
    exp_d(32'h12FFC, mem(32'h12FFC), 1'b1, 7);
    stall = 1'b0;
    newPC = 32'h3010;
    step();
    exp_d(32'h13000, ins_of(32'h13000, 1'b1), 1'b1, 8);
    exp_exc(1'b1);
    stall = 1'b1;
    step();
    exp_exc(1'b1);
    stall = 1'b0;
    flush = 1'b1;
    newPC = 32'h0;
    step();
    exp_d(32'h3010, 32'h0, 1'b0, 8);
    exp_exc(1'b0);
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
